lvl_gen: RTL

Pulse-to-level converter, the counterpart of the level-to-pulse block. It turns single-cycle event pulses into held level requests that stay asserted until the consumer acknowledges them, subject to a minimum hold time and a timeout. Pulses that arrive while a level is active are queued in a saturating pending counter and replayed, with a guaranteed low gap between consecutive levels. It sits between pulse-producing control logic and level-sensitive handshake inputs in the logical layer.

---
 rtl/lvl_gen_if.sv | 33 +++
 rtl/lvl_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lvl_gen_if.sv
// Handshake bundle between a pulse producer/level consumer and lvl_gen.
// The master side drives events and acknowledges; the slave side is the converter.
interface lvl_gen_if #(
    parameter int CNT_W = 2
);
    logic             pulse_sig;
    logic             lvl_ack;
    logic             lvl_sig;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             timeout_err;
    logic             overflow;

    modport master (
        output pulse_sig,
        output lvl_ack,
        input  lvl_sig,
        input  pending,
        input  busy,
        input  timeout_err,
        input  overflow
    );

    modport slave (
        input  pulse_sig,
        input  lvl_ack,
        output lvl_sig,
        output pending,
        output busy,
        output timeout_err,
        output overflow
    );
endinterface

// File: rtl/lvl_gen.sv
// Pulse-to-level converter: each event becomes a held level request that lasts
// until acknowledged (bounded by MIN_HOLD/TIMEOUT), with queued replay and a low gap.
module lvl_gen #(
    parameter int MIN_HOLD = 4,
    parameter int TIMEOUT  = 16,
    parameter int GAP      = 2,
    parameter int CNT_W    = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    lvl_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_e;

    localparam int HOLD_MAX = (TIMEOUT > MIN_HOLD) ? TIMEOUT : MIN_HOLD;
    localparam int HC_W     = $clog2(HOLD_MAX + 1);
    localparam int GC_W     = $clog2(GAP + 1);

    localparam logic [HC_W-1:0]  MIN_HOLD_C = HC_W'(MIN_HOLD);
    localparam logic [HC_W-1:0]  TIMEOUT_C  = HC_W'(TIMEOUT);
    localparam logic [HC_W-1:0]  HOLD_MAX_C = HC_W'(HOLD_MAX);
    localparam logic [GC_W-1:0]  GAP_C      = GC_W'(GAP);
    localparam logic [CNT_W-1:0] PEND_MAX   = '1;

    state_e           state_q;
    logic             lvl_q;
    logic             busy_q;
    logic             timeout_err_q;
    logic             overflow_q;
    logic             ack_seen_q;
    logic [HC_W-1:0]  hold_cnt_q;
    logic [GC_W-1:0]  gap_cnt_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;
    logic             overflow_d;

    logic ack_now;
    logic hold_done;
    logic hold_tmo;
    logic gap_run;
    logic restart;
    logic queue_evt;

    assign ack_now   = bus.lvl_ack | ack_seen_q;
    assign hold_done = ack_now && (hold_cnt_q >= MIN_HOLD_C);
    assign hold_tmo  = (TIMEOUT != 0) && (hold_cnt_q == TIMEOUT_C) && !ack_now;
    assign gap_run   = gap_cnt_q < GAP_C;
    assign restart   = (state_q == S_GAP) && !gap_run &&
                       ((pending_q != '0) || bus.pulse_sig);

    // A pulse is queued unless it is the event that starts a level this cycle.
    assign queue_evt = bus.pulse_sig &&
                       ((state_q == S_HOLD) || ((state_q == S_GAP) && gap_run));

    // NOTE: every output of this always_comb gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (queue_evt) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (restart && (pending_q != '0) && !bus.pulse_sig) begin
            pending_d = pending_q - 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            lvl_q         <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overflow_q    <= 1'b0;
            ack_seen_q    <= 1'b0;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            pending_q     <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            overflow_q    <= overflow_d;
            pending_q     <= pending_d;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.pulse_sig) begin
                        state_q    <= S_HOLD;
                        lvl_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= HC_W'(1);
                        ack_seen_q <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (hold_done) begin
                        state_q   <= S_GAP;
                        lvl_q     <= 1'b0;
                        gap_cnt_q <= GC_W'(1);
                    end else if (hold_tmo) begin
                        state_q       <= S_GAP;
                        lvl_q         <= 1'b0;
                        gap_cnt_q     <= GC_W'(1);
                        timeout_err_q <= 1'b1;
                    end else begin
                        // Saturate so a disabled timeout never wraps the counter.
                        if (hold_cnt_q != HOLD_MAX_C) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                        if (bus.lvl_ack) begin
                            ack_seen_q <= 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_run) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end else if (restart) begin
                        state_q    <= S_HOLD;
                        lvl_q      <= 1'b1;
                        hold_cnt_q <= HC_W'(1);
                        ack_seen_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    lvl_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lvl_sig     = lvl_q;
    assign bus.pending     = pending_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overflow    = overflow_q;

endmodule
